// File: rtl/dual_bank_regfile.sv
// Dual-bank (int/fp) register file with pair writes, pending scoreboard
// and registered hazards. Optional DUAL_BANK_REGFILE_BYPASS_EN forwards same-edge writes.
module dual_bank_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_we,
  input  logic [AW-1:0]     int_waddr,
  input  logic [DATA_W-1:0] int_wdata,
  input  logic              fp_we,
  input  logic              fp_dbl,
  input  logic [AW-1:0]     fp_waddr,
  input  logic [DATA_W-1:0] fp_wdata,
  input  logic [DATA_W-1:0] fp_wdata_hi,
  input  logic              rd_en,
  input  logic [AW-1:0]     int_raddr1,
  input  logic [AW-1:0]     int_raddr2,
  input  logic [AW-1:0]     fp_raddr1,
  input  logic [AW-1:0]     fp_raddr2,
  output logic [DATA_W-1:0] int_rdata1,
  output logic [DATA_W-1:0] int_rdata2,
  output logic [DATA_W-1:0] fp_rdata1,
  output logic [DATA_W-1:0] fp_rdata1_hi,
  output logic [DATA_W-1:0] fp_rdata2,
  output logic [DATA_W-1:0] fp_rdata2_hi,
  input  logic              sb_set,
  input  logic              sb_fp,
  input  logic              sb_dbl,
  input  logic [AW-1:0]     sb_addr,
  output logic              int_hz1,
  output logic              int_hz2,
  output logic              fp_hz1,
  output logic              fp_hz2
);

`ifdef DUAL_BANK_REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic [DATA_W-1:0] intMem [DEPTH];
  logic [DATA_W-1:0] fpMem  [DEPTH];
  logic [DEPTH-1:0]  intPend, fpPend;
  logic [DEPTH-1:0]  intWMask, fpWMask;
  logic [DEPTH-1:0]  intSMask, fpSMask;
  logic [DEPTH-1:0]  intEff, fpEff;
  logic [AW-1:0]     fpWaddrHi, sbAddrHi;
  logic [AW-1:0]     fpHi1, fpHi2;
  logic              intWrOk;
  logic [DATA_W-1:0] intNx1, intNx2;
  logic [DATA_W-1:0] fpNx1, fpNx1Hi, fpNx2, fpNx2Hi;

  assign intWrOk   = int_we && (int_waddr != '0);
  assign fpWaddrHi = fp_waddr + AW'(1);
  assign sbAddrHi  = sb_addr + AW'(1);
  assign fpHi1     = fp_raddr1 + AW'(1);
  assign fpHi2     = fp_raddr2 + AW'(1);

  always_comb begin
    intWMask = '0;
    fpWMask  = '0;
    intSMask = '0;
    fpSMask  = '0;
    if (intWrOk) intWMask[int_waddr] = 1'b1;
    if (fp_we) begin
      fpWMask[fp_waddr] = 1'b1;
      if (fp_dbl) fpWMask[fpWaddrHi] = 1'b1;
    end
    if (sb_set) begin
      if (sb_fp) begin
        fpSMask[sb_addr] = 1'b1;
        if (sb_dbl) fpSMask[sbAddrHi] = 1'b1;
      end else begin
        intSMask[sb_addr] = 1'b1;
        if (sb_dbl) intSMask[sbAddrHi] = 1'b1;
        intSMask[0] = 1'b0;
      end
    end
  end

  // Written entries report their post-edge pending state when forwarding
  assign intEff = Bypass ? ((intPend & ~intWMask) | (intSMask & intWMask))
                         : intPend;
  assign fpEff  = Bypass ? ((fpPend & ~fpWMask) | (fpSMask & fpWMask))
                         : fpPend;

  function automatic logic [DATA_W-1:0] fpPick(
    input logic [AW-1:0]     a,
    input logic [DATA_W-1:0] old
  );
    if (Bypass && fp_we && a == fp_waddr) return fp_wdata;
    if (Bypass && fp_we && fp_dbl && a == fpWaddrHi) return fp_wdata_hi;
    return old;
  endfunction

  assign intNx1  = (Bypass && intWMask[int_raddr1]) ? int_wdata
                                                    : intMem[int_raddr1];
  assign intNx2  = (Bypass && intWMask[int_raddr2]) ? int_wdata
                                                    : intMem[int_raddr2];
  assign fpNx1   = fpPick(fp_raddr1, fpMem[fp_raddr1]);
  assign fpNx1Hi = fpPick(fpHi1, fpMem[fpHi1]);
  assign fpNx2   = fpPick(fp_raddr2, fpMem[fp_raddr2]);
  assign fpNx2Hi = fpPick(fpHi2, fpMem[fpHi2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        intMem[i] <= '0;
        fpMem[i]  <= '0;
      end
      intPend      <= '0;
      fpPend       <= '0;
      int_rdata1   <= '0;
      int_rdata2   <= '0;
      fp_rdata1    <= '0;
      fp_rdata1_hi <= '0;
      fp_rdata2    <= '0;
      fp_rdata2_hi <= '0;
      int_hz1      <= 1'b0;
      int_hz2      <= 1'b0;
      fp_hz1       <= 1'b0;
      fp_hz2       <= 1'b0;
    end else begin
      if (intWrOk) intMem[int_waddr] <= int_wdata;
      if (fp_we) begin
        fpMem[fp_waddr] <= fp_wdata;
        if (fp_dbl) fpMem[fpWaddrHi] <= fp_wdata_hi;
      end
      intPend <= (intPend & ~intWMask) | intSMask;
      fpPend  <= (fpPend & ~fpWMask) | fpSMask;
      if (rd_en) begin
        int_rdata1   <= intNx1;
        int_rdata2   <= intNx2;
        fp_rdata1    <= fpNx1;
        fp_rdata1_hi <= fpNx1Hi;
        fp_rdata2    <= fpNx2;
        fp_rdata2_hi <= fpNx2Hi;
        int_hz1      <= intEff[int_raddr1];
        int_hz2      <= intEff[int_raddr2];
        fp_hz1       <= fpEff[fp_raddr1] | fpEff[fpHi1];
        fp_hz2       <= fpEff[fp_raddr2] | fpEff[fpHi2];
      end
    end
  end

endmodule

// File: doc/dual_bank_regfile.md
DUAL_BANK_REGFILE -- requirements
Module: dual_bank_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of every register entry.
REQ-002 SHALL have parameter DEPTH, default 32: entries per bank, power of two; AW = log2(DEPTH).
REQ-003 SHALL have ports clk in 1 (the single clock) and rst_n in 1 (asynchronous, active-low reset).
REQ-004 SHALL have int write ports: int_we in 1, write enable; int_waddr in AW, write address; int_wdata in DATA_W, write data.
REQ-005 SHALL have fp write ports: fp_we in 1, write enable; fp_dbl in 1, pair write; fp_waddr in AW, write address; fp_wdata in DATA_W, low word; fp_wdata_hi in DATA_W, high word.
REQ-006 SHALL have read controls: rd_en in 1, read enable; int_raddr1 and int_raddr2 in AW, int read addresses; fp_raddr1 and fp_raddr2 in AW, fp read addresses.
REQ-007 SHALL have read data outputs: int_rdata1 and int_rdata2 out DATA_W; fp_rdata1, fp_rdata1_hi, fp_rdata2 and fp_rdata2_hi out DATA_W.
REQ-008 SHALL have scoreboard ports: sb_set in 1, mark pending; sb_fp in 1, bank select (1 = fp); sb_dbl in 1, mark a pair; sb_addr in AW, address.
REQ-009 SHALL have hazard outputs: int_hz1, int_hz2, fp_hz1 and fp_hz2 out 1, one per read port.

Function
REQ-010 SHALL write both banks synchronously on rising clk; int and fp writes in the same cycle are independent.
REQ-011 SHALL ignore int writes to address 0; int entry 0 SHALL always read 0.
REQ-012 SHALL, on fp_we with fp_dbl=1, write fp_wdata to fp_waddr and fp_wdata_hi to (fp_waddr+1) mod DEPTH.
REQ-013 SHALL register all read outputs on the rising edge when rd_en=1 (latency 1 cycle) and hold them when rd_en=0.
REQ-014 SHALL drive each *_hi output from entry (raddr+1) mod DEPTH; address DEPTH-1 wraps to 0.
REQ-015 SHALL keep one pending bit per entry per bank; sb_set sets the bit at sb_addr, and also at (sb_addr+1) mod DEPTH when sb_dbl=1.
REQ-016 SHALL clear a pending bit on a write to that entry; a same-edge set of the same entry wins over the clear.
REQ-017 SHALL never set the pending bit of int entry 0.
REQ-018 SHALL register each hazard output with its data: it is the pending bit of the read address, OR the pending bit of the high entry for fp ports, sampled before the edge.

Reset
REQ-019 SHALL, while rst_n=0, clear all entries of both banks, all pending bits, all read data outputs and all hazard outputs to 0, regardless of clk.
REQ-020 SHALL ignore writes, sb_set and rd_en asserted in the same cycle as reset; reset mid-operation SHALL discard any write in flight.

Configuration
REQ-021 SHALL implement macro DUAL_BANK_REGFILE_BYPASS_EN.
REQ-022 With DUAL_BANK_REGFILE_BYPASS_EN defined, a read of an entry written on the same edge SHALL return the new data, including pair halves, and the hazard output for that entry SHALL be 0 unless the same edge also sets it.
REQ-023 Without DUAL_BANK_REGFILE_BYPASS_EN, a read on the same edge as a write to the same entry SHALL return the old data and the pre-edge hazard value.

Verification
REQ-024 The bench SHALL cover: int write 0xDEADBEEF to r5, then rd_en with int_raddr1=5 -> int_rdata1=0xDEADBEEF one cycle later; write to r0 -> int_rdata=0.
REQ-025 The bench SHALL cover: fp_dbl write to fp addr 31 with lo=0x11111111 and hi=0x22222222, then read addr 31 -> fp_rdata1=0x11111111 and fp_rdata1_hi=0x22222222 (hi stored in entry 0).
REQ-026 The bench SHALL cover: int write r7=0x5 and read r7 on the same edge -> 0x5 with macro, previous value without it.
REQ-027 The bench SHALL cover: sb_set fp addr 4 with sb_dbl=1, then read fp addr 3 -> fp_hz1=1 (hi entry 4 pending); fp write addr 4 -> next read fp_hz1=0.
REQ-028 The bench SHALL cover: sb_set and an int write to r9 on the same edge -> pending stays 1, and int_hz1 reads 1 next.
REQ-029 The bench SHALL cover: rst_n asserted mid-burst between clock edges -> all outputs 0 immediately, and every entry reads 0 after release.
